// File: rtl/lut_config_loader_if.sv
// ---------------------------------------------------------------------------
// lut_config_loader_if
//   Valid/ready chunk stream carrying the LUT configuration bitstream.
//
//   in_data   : one CONFIG_WIDTH-bit bitstream chunk
//   in_valid  : in_data holds a chunk (driven by the bitstream source)
//   in_ready  : loader accepts a chunk this cycle (driven by the loader)
//
//   master : bitstream source
//   slave  : lut_config_loader
// ---------------------------------------------------------------------------
interface lut_config_loader_if #(
  parameter int CONFIG_WIDTH = 4
);
  logic [CONFIG_WIDTH-1:0] in_data;
  logic                    in_valid;
  logic                    in_ready;

  modport master (output in_data, output in_valid, input  in_ready);
  modport slave  (input  in_data, input  in_valid, output in_ready);
endinterface

// File: rtl/lut_config_loader.sv
// ---------------------------------------------------------------------------
// lut_config_loader
//   Configuration-side driver for the block-configured LUT array. Collects
//   CHUNKS stream chunks into one MEM_SIZE-bit truth table, shows it on
//   config_out and fires a one-cycle one-hot cen strobe at the target LUT.
//   It walks LUT 0..NUM_LUTS-1 in order and then reports done.
//
//   cclk        : configuration clock (only clock)
//   rst_n       : synchronous active-low reset
//   start       : begin a load sequence (honoured in IDLE or DONE only)
//   in_if       : chunk stream (in_data / in_valid / in_ready)
//   config_out  : assembled truth table, shared by every LUT's config_in
//   cen         : one-hot commit strobe, bit i -> LUT i
//   busy        : sequence in progress (SHIFT or COMMIT)
//   done        : sequence complete (DONE)
//
//   Every output is a register, so no input reaches an output in the same
//   cycle.
// ---------------------------------------------------------------------------
module lut_config_loader #(
  parameter int INPUTS       = 4,
  parameter int MEM_SIZE     = 2**INPUTS,
  parameter int CONFIG_WIDTH = 4,
  parameter int NUM_LUTS     = 2
) (
  input  logic                 cclk,
  input  logic                 rst_n,
  input  logic                 start,
  lut_config_loader_if.slave   in_if,
  output logic [MEM_SIZE-1:0]  config_out,
  output logic [NUM_LUTS-1:0]  cen,
  output logic                 busy,
  output logic                 done
);

  localparam int CHUNKS = MEM_SIZE / CONFIG_WIDTH;
  localparam int CNT_W  = $clog2(CHUNKS) + 1;
  localparam int IDX_W  = $clog2(NUM_LUTS) + 1;

  localparam logic [CNT_W-1:0] LAST_CHUNK = CNT_W'(CHUNKS - 1);
  localparam logic [IDX_W-1:0] LAST_LUT   = IDX_W'(NUM_LUTS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_COMMIT,
    S_DONE
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   chunk_cnt;
  logic [IDX_W-1:0]   lut_idx;
  logic               in_ready_q;
  logic [MEM_SIZE-1:0] shifted;

  assign in_if.in_ready = in_ready_q;

  // New chunks enter at the MSBs and older ones slide toward bit 0, so the
  // first chunk of a LUT ends up in the low bits. With a single chunk per
  // LUT the chunk simply is the whole table.
  generate
    if (CHUNKS == 1) begin : g_single_chunk
      assign shifted = in_if.in_data;
    end else begin : g_multi_chunk
      assign shifted = {in_if.in_data, config_out[MEM_SIZE-1:CONFIG_WIDTH]};
    end
  endgenerate

  // NOTE: sequential state uses non-blocking assignments only, so every
  // right-hand side below reads the value from before this clock edge.
  always_ff @(posedge cclk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      config_out <= '0;
      cen        <= '0;
      in_ready_q <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      chunk_cnt  <= '0;
      lut_idx    <= '0;
    end else begin
      // cen is a single-cycle strobe: cleared every cycle unless the
      // SHIFT->COMMIT transition below raises it.
      cen <= '0;

      case (state)
        S_IDLE: begin
          if (start) begin
            state      <= S_SHIFT;
            chunk_cnt  <= '0;
            lut_idx    <= '0;
            in_ready_q <= 1'b1;
            busy       <= 1'b1;
          end
        end

        S_SHIFT: begin
          if (in_if.in_valid && in_ready_q) begin
            config_out <= shifted;
            if (chunk_cnt == LAST_CHUNK) begin
              chunk_cnt  <= '0;
              state      <= S_COMMIT;
              in_ready_q <= 1'b0;
              cen        <= NUM_LUTS'(1) << lut_idx;
            end else begin
              chunk_cnt <= chunk_cnt + CNT_W'(1);
            end
          end
        end

        S_COMMIT: begin
          if (lut_idx == LAST_LUT) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            lut_idx    <= lut_idx + IDX_W'(1);
            state      <= S_SHIFT;
            in_ready_q <= 1'b1;
          end
        end

        S_DONE: begin
          if (start) begin
            state      <= S_SHIFT;
            chunk_cnt  <= '0;
            lut_idx    <= '0;
            in_ready_q <= 1'b1;
            busy       <= 1'b1;
            done       <= 1'b0;
          end
        end

        default: begin
          state      <= S_IDLE;
          in_ready_q <= 1'b0;
          busy       <= 1'b0;
          done       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/lut_config_loader.md
Name: lut_config_loader

Overview:
- Configuration-side driver for the block-configured LUT array.
- Accepts a chunked bitstream over a valid/ready stream, assembles one MEM_SIZE-bit truth table per LUT, and presents it on config_out.
- Issues a single-cycle one-hot cen strobe to the target LUT, stepping through NUM_LUTS LUTs in order, then reports done.

Parameters:
- INPUTS, 4: LUT address width.
- MEM_SIZE, 2**INPUTS: config bits per LUT.
- CONFIG_WIDTH, 4: bits per stream chunk. MEM_SIZE must be a multiple of CONFIG_WIDTH; CHUNKS = MEM_SIZE/CONFIG_WIDTH.
- NUM_LUTS, 2: number of LUTs configured per load sequence.

Ports:
- cclk  in  1: configuration clock; the only clock.
- rst_n  in  1: synchronous, active-low reset, sampled on rising cclk.
- start  in  1: begin a load sequence; honoured only in IDLE or DONE.
- in_data  in  CONFIG_WIDTH: bitstream chunk.
- in_valid  in  1: in_data valid.
- in_ready  out  1: loader accepts a chunk this cycle.
- config_out  out  MEM_SIZE: assembled truth table; drives config_in of every LUT.
- cen  out  NUM_LUTS: one-hot commit strobe; bit i goes to LUT i.
- busy  out  1: high in SHIFT or COMMIT.
- done  out  1: high in DONE.

Behaviour:
- Reset (rst_n=0 at a cclk edge): state=IDLE, config_out=0, cen=0, in_ready=0, busy=0, done=0, chunk_cnt=0, lut_idx=0. Reset has priority over all other inputs. Reset mid-sequence aborts the sequence with no cen pulse, and partial data is discarded.
- States are IDLE, SHIFT, COMMIT and DONE. All outputs are registered or decoded from state; no combinational path from any input to any output.
- IDLE: in_ready=0. start=1 -> SHIFT, with chunk_cnt=0 and lut_idx=0.
- SHIFT:
  - in_ready=1.
  - Transfer: in_valid && in_ready at a cclk edge.
  - On each transfer, config_out <= {in_data, config_out[MEM_SIZE-1:CONFIG_WIDTH]}. The new chunk enters at the MSBs, so the first chunk of a LUT ends in bits [CONFIG_WIDTH-1:0].
  - chunk_cnt increments on each transfer. When the transfer is number CHUNKS, chunk_cnt returns to 0 and the state moves to COMMIT.
  - in_valid=0 stalls indefinitely with no state change. start is ignored.
- COMMIT:
  - Lasts exactly one cycle: cen[lut_idx]=1, all other cen bits 0, in_ready=0.
  - config_out holds its value through COMMIT and does not change until the next transfer.
  - Then: if lut_idx==NUM_LUTS-1 -> DONE. Otherwise lut_idx increments -> SHIFT.
- DONE: done=1, in_ready=0, config_out held. start=1 -> SHIFT with lut_idx=0 and done deasserting on the next cycle. No other exit except reset.
- cen is never asserted outside COMMIT, and never more than one bit at a time.
- Latency: the cen pulse occupies the cycle immediately after the cclk edge accepting the last chunk.
  - Minimum sequence length with in_valid held high: 1 (start) + NUM_LUTS*(CHUNKS+1) cycles to DONE.
  - Default parameters: 11 cycles.
- in_data while in_ready=0 is ignored; no overflow or underflow.
- Width rules: chunk_cnt is clog2(CHUNKS)+1 bits and lut_idx is clog2(NUM_LUTS)+1 bits. Wrap to 0 is explicit, not natural overflow.

Test Plan:
- Reset/idle: hold rst_n=0 for 3 cycles, then release with start=0 -> config_out=0, cen=0, in_ready=0, busy=0, done=0, stable for 10 cycles.
- Basic load (defaults):
  - Stimulus: start, then chunks 0x1,0x2,0x3,0x4 back-to-back.
  - Response: config_out=0x4321 and cen=2'b01 for exactly one cycle, in_ready=0 that cycle.
  - Stimulus: chunks 0xA,0xB,0xC,0xD.
  - Response: config_out=0xDCBA and cen=2'b10, then done=1.
  - Check: a behavioural LUT pair captures 0x4321 / 0xDCBA.
- Stalls: same data with in_valid toggling 1,0,0,1 randomly -> identical cen timing relative to the 4th accepted chunk; no extra transfers; in_data changes while in_valid=0 are ignored.
- Reset mid-operation: rst_n=0 after 2 chunks of LUT 1 -> no cen pulse, state IDLE, config_out=0. A fresh full sequence then configures LUT 0 first.
- Restart from DONE:
  - Complete one sequence.
  - Assert start while start is also pulsed during SHIFT -> the mid-SHIFT start is ignored, and the DONE start restarts at lut_idx=0.
  - Second sequence with 0xF,0xF,0xF,0xF -> config_out=0xFFFF with cen=2'b01.
- Parameter sweep: INPUTS=3, CONFIG_WIDTH=8, NUM_LUTS=4 (CHUNKS=1).
  - Response: each chunk is followed by a one-cycle cen pulse 4'b0001, 4'b0010, 4'b0100, 4'b1000 in order.
  - Response: DONE is reached 9 cycles after start when in_valid is held high.
